// File: rtl/riscv_structures.sv
// Shared RISC-V core definitions: register-file defaults and dump FSM encoding.
package riscv_structures;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  typedef enum logic [1:0] {RF_IDLE, RF_DUMP, RF_DONE} rf_dump_state_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-writeback tracker; decode stalls on rbusy for its sources.
module rf_scoreboard #(
  parameter int NREGS = 32,
  parameter int NW    = 1,
  parameter int NR    = 2,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NW-1:0]          we,
  input  logic [NW-1:0][AW-1:0]  wa,
  input  logic                   iss_valid,
  input  logic [AW-1:0]          iss_rd,
  input  logic [NR-1:0][AW-1:0]  ra,
  output logic [NR-1:0]          rbusy,
  output logic [NREGS-1:0]       busy
);

  logic [NREGS-1:0] busy_nxt;

  // Clears are applied first so a same-cycle issue (new producer) wins.
  always_comb begin
    busy_nxt = busy;
    for (int i = 0; i < NW; i++)
      if (we[i] && wa[i] != '0) busy_nxt[wa[i]] = 1'b0;
    if (iss_valid && iss_rd != '0) busy_nxt[iss_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  for (genvar j = 0; j < NR; j++) begin : g_rbusy
    logic hit;
    always_comb begin
      hit = 1'b0;
      for (int i = 0; i < NW; i++)
        if (we[i] && wa[i] == ra[j]) hit = 1'b1;
    end
    // A value arriving through the bypass this cycle is already usable.
    assign rbusy[j] = (ra[j] != '0) && busy[ra[j]] && !hit;
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port integer register file with write-to-read bypass, busy scoreboard
// and a one-register-per-cycle debug dump.
module reg_file_mp
  import riscv_structures::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NR    = 2,
  parameter int NW    = 1,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NR-1:0][AW-1:0]   ra,
  output logic [NR-1:0][XLEN-1:0] rd,
  output logic [NR-1:0]           rbusy,
  input  logic [NW-1:0]           we,
  input  logic [NW-1:0][AW-1:0]   wa,
  input  logic [NW-1:0][XLEN-1:0] wd,
  input  logic                    iss_valid,
  input  logic [AW-1:0]           iss_rd,
  input  logic                    dump,
  output logic                    dump_done
);

  logic [NREGS-1:0][XLEN-1:0] regs;
  logic [NREGS-1:0]           busy;

  // Ascending port order makes the highest-indexed writer win on conflicts.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs <= '0;
    end else begin
      for (int i = 0; i < NW; i++)
        if (we[i] && wa[i] != '0) regs[wa[i]] <= wd[i];
    end
  end

  for (genvar j = 0; j < NR; j++) begin : g_rd
    logic [XLEN-1:0] v;
    always_comb begin
      v = regs[ra[j]];
      for (int i = 0; i < NW; i++)
        if (we[i] && wa[i] == ra[j]) v = wd[i];
      if (ra[j] == '0) v = '0;
    end
    assign rd[j] = v;
  end

  rf_scoreboard #(
    .NREGS (NREGS),
    .NW    (NW),
    .NR    (NR),
    .AW    (AW)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .wa        (wa),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .ra        (ra),
    .rbusy     (rbusy),
    .busy      (busy)
  );

  rf_dump_state_t state, state_nxt;
  logic [AW-1:0]  idx, idx_nxt;
  logic           dump_q;
  logic           dump_rise;

  assign dump_rise = dump && !dump_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RF_IDLE;
      idx    <= '0;
      dump_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      idx    <= idx_nxt;
      dump_q <= dump;
    end
  end

  // Edges seen outside IDLE are dropped, not queued.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    dump_done = 1'b0;
    case (state)
      RF_IDLE: if (dump_rise) begin
        state_nxt = RF_DUMP;
        idx_nxt   = '0;
      end
      RF_DUMP: if (idx == AW'(NREGS - 1)) state_nxt = RF_DONE;
               else                       idx_nxt   = idx + 1'b1;
      RF_DONE: begin
        dump_done = 1'b1;
        state_nxt = RF_IDLE;
      end
      default: state_nxt = RF_IDLE;
    endcase
  end

`ifndef SYNTHESIS
  always @(posedge clk)
    if (!rst && state == RF_DUMP)
      $display("reg_file_mp dump: x%0d = 0x%h busy=%0b", idx, regs[idx], busy[idx]);
`endif

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard-driven bench for reg_file_mp (NR=2, NW=2).
module tb_reg_file_mp;
  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int NR = 2;
  localparam int NW = 2;
  localparam int AW = 5;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NR-1:0][AW-1:0]   ra;
  logic [NR-1:0][XLEN-1:0] rd;
  logic [NR-1:0]           rbusy;
  logic [NW-1:0]           we;
  logic [NW-1:0][AW-1:0]   wa;
  logic [NW-1:0][XLEN-1:0] wd;
  logic                    iss_valid;
  logic [AW-1:0]           iss_rd;
  logic                    dump;
  logic                    dump_done;

  reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NR(NR), .NW(NW)) dut (
    .clk(clk), .rst(rst), .ra(ra), .rd(rd), .rbusy(rbusy),
    .we(we), .wa(wa), .wd(wd), .iss_valid(iss_valid), .iss_rd(iss_rd),
    .dump(dump), .dump_done(dump_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string           nm;
    int              port;
    logic [XLEN-1:0] d;
    logic            b;
  } exp_t;

  exp_t q[$];
  bit   dq[$];
  int   n_checks = 0;
  int   n_fail = 0;

  logic [XLEN-1:0] m_regs [NREGS];
  bit              m_busy [NREGS];

  task automatic idle_inputs();
    we = '0; wa = '0; wd = '0; iss_valid = 1'b0; iss_rd = '0; dump = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    @(negedge clk);
    rst = 1'b1; idle_inputs(); ra = '0;
    we = 2'b11; wa[0] = 5'd0; wd[0] = 32'hDEADBEEF; wa[1] = 5'd3; wd[1] = 32'hCAFE0003;
    iss_valid = 1'b1; iss_rd = 5'd4;
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (dump_done !== 1'b0) begin
      n_fail++; $display("FAIL reset_dump_done: got %b want 0", dump_done);
    end
    we[0] = 1'b1; wa[0] = 5'd0; wd[0] = 32'hDEADBEEF; ra[0] = 5'd0; ra[1] = 5'd0;
    q.push_back('{"x0_write", 0, 32'h0, 1'b0});
    q.push_back('{"x0_write", 1, 32'h0, 1'b0});
    #1;
    while (q.size() > 0) begin
      e = q.pop_front(); n_checks++;
      if (rd[e.port] !== e.d || rbusy[e.port] !== e.b) begin
        n_fail++;
        $display("FAIL %s p%0d: rd=%h rbusy=%b want rd=%h rbusy=%b", e.nm, e.port, rd[e.port], rbusy[e.port], e.d, e.b);
      end
    end
    @(negedge clk);
    idle_inputs();
    for (int r = 0; r < NREGS; r += 2) begin
      ra[0] = AW'(r); ra[1] = AW'(r + 1);
      q.push_back('{$sformatf("reset_x%0d", r), 0, 32'h0, 1'b0});
      q.push_back('{$sformatf("reset_x%0d", r + 1), 1, 32'h0, 1'b0});
      #1;
      while (q.size() > 0) begin
        e = q.pop_front(); n_checks++;
        if (rd[e.port] !== e.d || rbusy[e.port] !== e.b) begin
          n_fail++;
          $display("FAIL %s p%0d: rd=%h rbusy=%b want rd=%h rbusy=%b", e.nm, e.port, rd[e.port], rbusy[e.port], e.d, e.b);
        end
      end
    end
  endtask

  task automatic test_bypass();
    exp_t e;
    @(negedge clk);
    idle_inputs();
    we[0] = 1'b1; wa[0] = 5'd5; wd[0] = 32'h12345678; ra[0] = 5'd5; ra[1] = 5'd6;
    q.push_back('{"bypass_same", 0, 32'h12345678, 1'b0});
    q.push_back('{"bypass_other", 1, 32'h0, 1'b0});
    #1;
    while (q.size() > 0) begin
      e = q.pop_front(); n_checks++;
      if (rd[e.port] !== e.d || rbusy[e.port] !== e.b) begin
        n_fail++;
        $display("FAIL %s p%0d: rd=%h rbusy=%b want rd=%h rbusy=%b", e.nm, e.port, rd[e.port], rbusy[e.port], e.d, e.b);
      end
    end
    @(negedge clk);
    idle_inputs(); ra[1] = 5'd5;
    q.push_back('{"bypass_stored", 0, 32'h12345678, 1'b0});
    q.push_back('{"bypass_stored", 1, 32'h12345678, 1'b0});
    #1;
    while (q.size() > 0) begin
      e = q.pop_front(); n_checks++;
      if (rd[e.port] !== e.d || rbusy[e.port] !== e.b) begin
        n_fail++;
        $display("FAIL %s p%0d: rd=%h rbusy=%b want rd=%h rbusy=%b", e.nm, e.port, rd[e.port], rbusy[e.port], e.d, e.b);
      end
    end
  endtask

  task automatic test_conflict();
    exp_t e;
    @(negedge clk);
    idle_inputs();
    we = 2'b11; wa[0] = 5'd7; wd[0] = 32'h1; wa[1] = 5'd7; wd[1] = 32'h2;
    ra[0] = 5'd7; ra[1] = 5'd5;
    q.push_back('{"conflict_bypass", 0, 32'h2, 1'b0});
    q.push_back('{"conflict_other", 1, 32'h12345678, 1'b0});
    #1;
    while (q.size() > 0) begin
      e = q.pop_front(); n_checks++;
      if (rd[e.port] !== e.d || rbusy[e.port] !== e.b) begin
        n_fail++;
        $display("FAIL %s p%0d: rd=%h rbusy=%b want rd=%h rbusy=%b", e.nm, e.port, rd[e.port], rbusy[e.port], e.d, e.b);
      end
    end
    @(negedge clk);
    idle_inputs(); ra[1] = 5'd7;
    q.push_back('{"conflict_stored", 1, 32'h2, 1'b0});
    #1;
    while (q.size() > 0) begin
      e = q.pop_front(); n_checks++;
      if (rd[e.port] !== e.d || rbusy[e.port] !== e.b) begin
        n_fail++;
        $display("FAIL %s p%0d: rd=%h rbusy=%b want rd=%h rbusy=%b", e.nm, e.port, rd[e.port], rbusy[e.port], e.d, e.b);
      end
    end
  endtask

  task automatic test_scoreboard();
    exp_t e;
    // step: 0 issue x3, 1 observe busy, 2 write x3, 3 observe cleared,
    //       4 issue+write x3, 5 observe still busy, 6 issue x0, 7 observe x0
    for (int s = 0; s < 8; s++) begin
      @(negedge clk);
      idle_inputs(); ra[0] = 5'd3; ra[1] = 5'd0;
      case (s)
        0: begin iss_valid = 1'b1; iss_rd = 5'd3;
                 q.push_back('{"sb_issue_same", 0, 32'h0, 1'b0}); end
        1: q.push_back('{"sb_busy_next", 0, 32'h0, 1'b1});
        2: begin we[0] = 1'b1; wa[0] = 5'd3; wd[0] = 32'hA;
                 q.push_back('{"sb_write_bypass", 0, 32'hA, 1'b0}); end
        3: q.push_back('{"sb_cleared", 0, 32'hA, 1'b0});
        4: begin iss_valid = 1'b1; iss_rd = 5'd3; we[1] = 1'b1; wa[1] = 5'd3; wd[1] = 32'hB;
                 q.push_back('{"sb_set_clr_same", 0, 32'hB, 1'b0}); end
        5: q.push_back('{"sb_set_wins", 0, 32'hB, 1'b1});
        6: begin iss_valid = 1'b1; iss_rd = 5'd0; end
        default: q.push_back('{"sb_x0_ignored", 1, 32'h0, 1'b0});
      endcase
      #1;
      while (q.size() > 0) begin
        e = q.pop_front(); n_checks++;
        if (rd[e.port] !== e.d || rbusy[e.port] !== e.b) begin
          n_fail++;
          $display("FAIL %s p%0d: rd=%h rbusy=%b want rd=%h rbusy=%b", e.nm, e.port, rd[e.port], rbusy[e.port], e.d, e.b);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [XLEN-1:0] d;
    bit hit;
    for (int r = 0; r < NREGS; r++) begin m_regs[r] = '0; m_busy[r] = 1'b0; end
    m_regs[5] = 32'h12345678; m_regs[7] = 32'h2; m_regs[3] = 32'hB; m_busy[3] = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      idle_inputs();
      for (int i = 0; i < NW; i++) begin
        we[i] = 1'($urandom_range(0, 1));
        wa[i] = AW'($urandom_range(0, NREGS - 1));
        wd[i] = $urandom;
      end
      iss_valid = 1'($urandom_range(0, 1));
      iss_rd = AW'($urandom_range(0, NREGS - 1));
      for (int j = 0; j < NR; j++)
        ra[j] = (c % 3 == 0) ? wa[j] : AW'($urandom_range(0, NREGS - 1));
      for (int j = 0; j < NR; j++) begin
        d = (ra[j] == '0) ? '0 : m_regs[ra[j]];
        hit = 1'b0;
        for (int i = 0; i < NW; i++)
          if (we[i] && wa[i] == ra[j] && ra[j] != '0) begin d = wd[i]; hit = 1'b1; end
        q.push_back('{$sformatf("b2b_c%0d", c), j, d, (ra[j] != '0) && m_busy[ra[j]] && !hit});
      end
      #1;
      while (q.size() > 0) begin
        e = q.pop_front(); n_checks++;
        if (rd[e.port] !== e.d || rbusy[e.port] !== e.b) begin
          n_fail++;
          $display("FAIL %s p%0d: rd=%h rbusy=%b want rd=%h rbusy=%b", e.nm, e.port, rd[e.port], rbusy[e.port], e.d, e.b);
        end
      end
      for (int i = 0; i < NW; i++)
        if (we[i] && wa[i] != '0) begin m_regs[wa[i]] = wd[i]; m_busy[wa[i]] = 1'b0; end
      if (iss_valid && iss_rd != '0) m_busy[iss_rd] = 1'b1;
    end
  endtask

  task automatic test_dump();
    exp_t e;
    bit got;
    @(negedge clk);
    idle_inputs(); we[0] = 1'b1; wa[0] = 5'd1; wd[0] = 32'h11;
    @(negedge clk);
    idle_inputs(); dump = 1'b1;
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      we = '0;
      if (k == 5)  dump = 1'b0;
      if (k == 10) dump = 1'b1;
      if (k == 20) begin we[0] = 1'b1; wa[0] = 5'd2; wd[0] = 32'h22; end
      if (k == 21) begin
        ra[1] = 5'd2;
        q.push_back('{"dump_write_during", 1, 32'h22, 1'b0});
      end
      dq.push_back(k == 33);
      #1;
      got = dq.pop_front(); n_checks++;
      if (dump_done !== got) begin
        n_fail++; $display("FAIL dump_done_cycle%0d: got %b want %b", k, dump_done, got);
      end
      while (q.size() > 0) begin
        e = q.pop_front(); n_checks++;
        if (rd[e.port] !== e.d || rbusy[e.port] !== e.b) begin
          n_fail++;
          $display("FAIL %s p%0d: rd=%h rbusy=%b want rd=%h rbusy=%b", e.nm, e.port, rd[e.port], rbusy[e.port], e.d, e.b);
        end
      end
    end
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_reset_mid_dump();
    exp_t e;
    int pulses = 0;
    @(negedge clk);
    idle_inputs(); iss_valid = 1'b1; iss_rd = 5'd9; we[0] = 1'b1; wa[0] = 5'd4; wd[0] = 32'h44;
    @(negedge clk);
    idle_inputs(); dump = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (dump_done) pulses++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; dump = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (dump_done) pulses++;
    end
    n_checks++;
    if (pulses !== 0) begin
      n_fail++; $display("FAIL mid_dump_reset_pulse: got %0d pulses want 0", pulses);
    end
    for (int r = 0; r < NREGS; r += 2) begin
      @(negedge clk);
      ra[0] = AW'(r); ra[1] = AW'(r + 1);
      q.push_back('{$sformatf("mid_reset_x%0d", r), 0, 32'h0, 1'b0});
      q.push_back('{$sformatf("mid_reset_x%0d", r + 1), 1, 32'h0, 1'b0});
      #1;
      while (q.size() > 0) begin
        e = q.pop_front(); n_checks++;
        if (rd[e.port] !== e.d || rbusy[e.port] !== e.b) begin
          n_fail++;
          $display("FAIL %s p%0d: rd=%h rbusy=%b want rd=%h rbusy=%b", e.nm, e.port, rd[e.port], rbusy[e.port], e.d, e.b);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; ra = '0; idle_inputs();
    test_reset();
    test_bypass();
    test_conflict();
    test_scoreboard();
    test_back_to_back();
    test_dump();
    test_reset_mid_dump();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-port integer register file with write-to-read bypass and a per-register busy scoreboard, for the pipelined and superscalar RISC-V cores. Replaces the single-write, two-read register file in the decode/writeback stages. The block provides:
- `NR` combinational read ports and `NW` synchronous write ports.
- Register 0 hardwired to zero.
- A scoreboard that marks registers pending writeback, so decode can stall on hazards.
- A snapshot dump port for the bench.

## Interface
Parameters:
- `XLEN`, 32: data width.
- `NREGS`, 32: register count; power of two, ≥ 2.
- `NR`, 2: number of read ports, 1..4.
- `NW`, 1: number of write ports, 1..2.
- `AW`, `$clog2(NREGS)`: address width (derived; do not override).

Ports:
- `clk`, in, 1: clock; all state updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `ra`, in, `NR×AW`: read addresses.
- `rd`, out, `NR×XLEN`: read data.
- `rbusy`, out, `NR`: the addressed register has a pending writeback.
- `we`, in, `NW`: write enables.
- `wa`, in, `NW×AW`: write addresses.
- `wd`, in, `NW×XLEN`: write data.
- `iss_valid`, in, 1: issue of an instruction with destination `iss_rd`; marks it busy.
- `iss_rd`, in, `AW`: destination of the issuing instruction.
- `dump`, in, 1: rising-edge request to print all registers and busy bits.
- `dump_done`, out, 1: one-cycle pulse when the dump finishes.

## Operation
- **Register 0:**
  - Reads of address 0 return 0 with `rbusy`=0.
  - Writes to 0 are dropped.
  - `iss_valid` with `iss_rd`=0 is ignored.
- **Write:** on a rising edge with `we[i]`=1 and `wa[i]`≠0, `regs[wa[i]] <= wd[i]`.
  - Two ports with the same nonzero address in the same cycle: the higher port index wins.
- **Read:** combinational.
  - If any `we[i]` targets `ra[j]` (≠0) this cycle, `rd[j]` is that `wd[i]` (highest index wins).
  - Otherwise `rd[j]` is the stored value.
- **Scoreboard:** `busy[NREGS]`.
  - A write to a nonzero address clears `busy[addr]`.
  - `iss_valid` sets `busy[iss_rd]`.
  - Set and clear of the same register in the same cycle: **set wins**, because a new producer is in flight.
- **`rbusy[j]`:** `busy[ra[j]]` AND NOT (a write to `ra[j]` this cycle). A bypassed value is never reported busy.
- **Dump FSM:** states IDLE → DUMP → DONE → IDLE.
  - IDLE: a rising edge on `dump` (registered edge detect) enters DUMP with index 0.
  - DUMP: prints one register per cycle (`$display` of index, value, busy). After index `NREGS-1`, goes to DONE.
  - DONE: `dump_done`=1 for one cycle, then IDLE.
  - `dump` edges during DUMP or DONE are ignored.
  - Writes continue during a dump. Each printed value is the contents at the cycle it is printed.

## Timing
- Read latency 0; write visible in storage 1 cycle after the edge; bypass makes it visible to reads in the same cycle.
- Issue to busy: `rbusy` asserts for reads in the cycle after `iss_valid`.
- Reset:
  - All registers = 0, all `busy` = 0.
  - FSM = IDLE, index = 0, `dump_done` = 0, edge-detect flop = 0.
  - Writes, issues and dump edges in the reset cycle are discarded.
  - Reset during DUMP aborts with no `dump_done` pulse.
- There is no `initial` block for state; all initialisation comes through `rst`.

## Structure
- The shared package `riscv_structures` gains:
  - `XLEN_DEF`=32 and `NREGS_DEF`=32.
  - `typedef enum logic [1:0] {RF_IDLE, RF_DUMP, RF_DONE} rf_dump_state_t`.
- One sub-module, `rf_scoreboard`, parametrised on `NREGS`, `NW` and `NR`. It holds `busy`, applies the set/clear priority and computes `rbusy`.
- Storage, bypass and the dump FSM stay in `reg_file_mp`.

## Test plan
- **Reset and x0:** assert `rst`, then write `wa`=0, `wd`=0xDEADBEEF → `rd` for `ra`=0 reads 0; all 32 registers read 0 after reset.
- **Bypass:** `we[0]`=1, `wa`=5, `wd`=0x12345678 with `ra[0]`=5 in the same cycle → `rd[0]`=0x12345678 in that cycle, and in the next cycle with `we`=0.
- **Write conflict** (`NW`=2): port 0 writes x7=0x1, port 1 writes x7=0x2 → same-cycle bypass and the stored value are both 0x2.
- **Scoreboard:**
  - `iss_valid`, `iss_rd`=3 → `rbusy` for x3 is 1 from the next cycle.
  - Write x3=0xA → `rbusy` is 0 in that cycle, with `rd`=0xA.
  - Simultaneous issue and write of x3 → x3 stays busy.
- **Dump:** pulse `dump` with x1=0x11 → 32 lines printed on consecutive cycles, then `dump_done` high for exactly 1 cycle, 33 cycles after the detected edge.
- **Reset mid-dump:** assert `rst` at index 10 → FSM returns to IDLE, `dump_done` never pulses, all registers and busy bits are 0.
